// File: rtl/rf_dump_tx_pkg.sv
// Shared definitions for the register-file dump link.
// Holds the frame FSM state encoding, the default frame parameters and the
// payload byte-order rule. The host-side decoder and its models should use
// the same byte-order helper so both ends agree on the order.
package rf_dump_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_SUM  = 2'd3
  } state_e;

  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam int         NBYTES_DEF = 28;
  localparam int         IDX_W      = 5;

  // Payload byte idx is taken from this bit offset of the dump vector.
  // Byte 0 is the most significant byte (register A). The last byte is bits [7:0] (T2).
  function automatic int payload_lsb(input logic [IDX_W-1:0] idx, input int nbytes);
    return (nbytes - 1 - int'(idx)) * 8;
  endfunction

endpackage

// File: rtl/rf_dump_tx.sv
// rf_dump_tx: debug-side transmitter for the register-file dump bus.
// A Trig pulse snapshots DEBUG_RF_dump. The snapshot is then sent as one frame
// over a valid/ready byte interface:
//   HEADER, NBYTES payload bytes (MSB first), CHK.
// CHK is chosen so that the sum of the payload bytes plus CHK is 0 mod 256.
//
// Ports:
//   CLK           in   system clock
//   RST           in   asynchronous active-high reset
//   DEBUG_RF_dump in   NBYTES*8 register-file dump vector
//   Trig          in   capture request, sampled each posedge
//   Tx_ready      in   downstream can accept a byte
//   Tx_valid      out  Tx_data holds a valid byte
//   Tx_data       out  byte being offered
//   Busy          out  a frame is in progress
//   Drop_cnt      out  saturating count of triggers ignored while busy
module rf_dump_tx
  import rf_dump_tx_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter int         NBYTES = NBYTES_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NBYTES*8-1:0] DEBUG_RF_dump,
  input  logic                Trig,
  input  logic                Tx_ready,
  output logic                Tx_valid,
  output logic [7:0]          Tx_data,
  output logic                Busy,
  output logic [7:0]          Drop_cnt
);

  localparam int               SNAP_W   = NBYTES * 8;
  localparam int               SEL_W    = $clog2(SNAP_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  state_e             state_q, state_d;
  logic [SNAP_W-1:0]  snap_q;
  logic [7:0]         sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [7:0]         drop_q, drop_d;
  logic               capture;

  logic               accept;
  logic               last;
  logic               take_trig;
  logic [7:0]         run_sum;
  logic [IDX_W-1:0]   idx_nx;
  logic [SEL_W-1:0]   sel_first, sel_nx;

  assign accept    = tx_valid_q & Tx_ready;
  assign last      = (idx_q == IDX_LAST);
  assign idx_nx    = idx_q + IDX_W'(1);
  assign sel_first = SEL_W'(payload_lsb(IDX_W'(0), NBYTES));
  assign sel_nx    = SEL_W'(payload_lsb(idx_nx, NBYTES));
  // Add the byte now being accepted to the running sum. CHK is then ready at
  // the DATA->SUM edge, so there is no bubble before the checksum byte.
  assign run_sum   = sum_q + tx_data_q;
  // A trigger is taken in IDLE. It is also taken in SUM when it arrives on the
  // same cycle as the CHK accept (back-to-back frames). Any other trigger is dropped.
  assign take_trig = (state_q == ST_IDLE) | ((state_q == ST_SUM) & accept);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (Trig)           state_d = ST_HDR;
      ST_HDR:  if (accept)         state_d = ST_DATA;
      ST_DATA: if (accept && last) state_d = ST_SUM;
      ST_SUM:  if (accept)         state_d = Trig ? ST_HDR : ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    capture    = 1'b0;
    sum_d      = sum_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Trig) begin
          capture    = 1'b1;
          sum_d      = 8'h00;
          idx_d      = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = HEADER;
        end
      end
      ST_HDR: begin
        // The snapshot was captured on entry to HDR, so it is stable here.
        if (accept) begin
          idx_d     = '0;
          tx_data_d = snap_q[sel_first +: 8];
        end
      end
      ST_DATA: begin
        if (accept) begin
          sum_d = run_sum;
          if (last) begin
            tx_data_d = 8'h00 - run_sum;
          end else begin
            idx_d     = idx_nx;
            tx_data_d = snap_q[sel_nx +: 8];
          end
        end
      end
      ST_SUM: begin
        if (accept) begin
          if (Trig) begin
            capture   = 1'b1;
            sum_d     = 8'h00;
            idx_d     = '0;
            tx_data_d = HEADER;
          end else begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
          end
        end
      end
      default: begin
        tx_valid_d = 1'b0;
      end
    endcase

    drop_d = drop_q;
    if (Trig && !take_trig && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Registered outputs and datapath
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum_q      <= 8'h00;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      drop_q     <= 8'h00;
    end else begin
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      drop_q     <= drop_d;
    end
  end

  // The snapshot needs no reset value: it is only read after a capture.
  always_ff @(posedge CLK) begin
    if (capture) snap_q <= DEBUG_RF_dump;
  end

  assign Tx_valid = tx_valid_q;
  assign Tx_data  = tx_data_q;
  assign Busy     = (state_q != ST_IDLE);
  assign Drop_cnt = drop_q;

endmodule

// File: tb/tb_rf_dump_tx.sv
// Scoreboard bench for rf_dump_tx. Stimulus pushes expected frame bytes into a
// queue; a monitor pops and compares on every accepted byte and checks handshake
// stability while stalled.
module tb_rf_dump_tx;

  localparam int NB = 28;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [223:0]  DEBUG_RF_dump = '0;
  logic          Trig = 1'b0;
  logic          Tx_ready = 1'b0;
  logic          Tx_valid;
  logic [7:0]    Tx_data;
  logic          Busy;
  logic [7:0]    Drop_cnt;

  int            checks = 0;
  int            errors = 0;
  int            acc_cnt = 0;
  logic [7:0]    exp_q[$];

  always #5 CLK = ~CLK;

  rf_dump_tx dut (
    .CLK           (CLK),
    .RST           (RST),
    .DEBUG_RF_dump (DEBUG_RF_dump),
    .Trig          (Trig),
    .Tx_ready      (Tx_ready),
    .Tx_valid      (Tx_valid),
    .Tx_data       (Tx_data),
    .Busy          (Busy),
    .Drop_cnt      (Drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [223:0] pat_inc();
    logic [223:0] v;
    for (int i = 0; i < NB; i++) v[(NB-1-i)*8 +: 8] = 8'(i + 1);
    return v;
  endfunction

  function automatic logic [223:0] pat_rand();
    logic [223:0] v;
    for (int i = 0; i < 7; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic push_frame(input logic [223:0] d, input logic [7:0] chk_byte);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NB; i++) exp_q.push_back(d[(NB-1-i)*8 +: 8]);
    exp_q.push_back(chk_byte);
  endtask

  task automatic push_auto(input logic [223:0] d);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < NB; i++) s = s + d[(NB-1-i)*8 +: 8];
    push_frame(d, 8'h00 - s);
  endtask

  task automatic send_trig();
    @(posedge CLK); #1 Trig = 1'b1;
    @(posedge CLK); #1 Trig = 1'b0;
    chk("lat_valid", 32'(Tx_valid), 32'd1);
    chk("lat_header", 32'(Tx_data), 32'hA5);
    chk("lat_busy", 32'(Busy), 32'd1);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (Busy && cyc < 5000) begin
      @(posedge CLK); #1;
      cyc++;
    end
    if (Busy) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout actual=busy required=idle");
    end
  endtask

  // Monitor: compares accepted bytes and checks stall stability.
  initial begin : monitor
    bit         held;
    logic [7:0] hd;
    logic [7:0] e;
    held = 1'b0;
    hd   = 8'h00;
    forever begin
      @(negedge CLK);
      if (RST) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(Tx_valid), 32'd1);
          chk("hold_data", 32'(Tx_data), 32'(hd));
        end
        chk("valid_vs_busy", 32'(Tx_valid), 32'(Busy));
        if (Tx_valid && Tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", Tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("stream_byte", 32'(Tx_data), 32'(e));
          end
          acc_cnt++;
          held = 1'b0;
        end else if (Tx_valid) begin
          held = 1'b1;
          hd   = Tx_data;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int            a0;
    int            cyc;
    logic [223:0]  p;
    logic [223:0]  pb;

    // Reset state
    #12;
    chk("rst_valid", 32'(Tx_valid), 32'd0);
    chk("rst_data", 32'(Tx_data), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_drop", 32'(Drop_cnt), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;

    // Basic frame: 01..1C, CHK 6A
    Tx_ready = 1'b1;
    DEBUG_RF_dump = pat_inc();
    push_frame(pat_inc(), 8'h6A);
    a0 = acc_cnt;
    send_trig();
    wait_idle(cyc);
    chk("basic_accepts", 32'(acc_cnt - a0), 32'd30);
    chk("basic_cycles", 32'(cyc), 32'd30);
    chk("basic_valid_low", 32'(Tx_valid), 32'd0);

    // All-FF payload: sum = -28, CHK 1C
    DEBUG_RF_dump = {224{1'b1}};
    push_frame({224{1'b1}}, 8'h1C);
    send_trig();
    wait_idle(cyc);

    // All-zero payload: CHK 00
    DEBUG_RF_dump = '0;
    push_frame('0, 8'h00);
    send_trig();
    wait_idle(cyc);
    chk("zero_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure with mid-frame dump change
    DEBUG_RF_dump = pat_inc();
    push_frame(pat_inc(), 8'h6A);
    Tx_ready = 1'b0;
    send_trig();
    for (int k = 0; k < 3000 && Busy; k++) begin
      @(posedge CLK); #1;
      Tx_ready = ($urandom_range(0, 9) < 3);
      if (k == 5) DEBUG_RF_dump = {7{32'hDEADBEEF}};
    end
    wait_idle(cyc);
    Tx_ready = 1'b1;
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Drops: Trig held 300 cycles with Tx_ready low
    Tx_ready = 1'b0;
    p = pat_rand();
    DEBUG_RF_dump = p;
    push_auto(p);
    @(posedge CLK); #1 Trig = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("drop_9", 32'(Drop_cnt), 32'd9);
    chk("drop_hdr_held", 32'(Tx_data), 32'hA5);
    repeat (290) @(posedge CLK);
    #1;
    chk("drop_sat", 32'(Drop_cnt), 32'd255);
    Trig = 1'b0;
    Tx_ready = 1'b1;
    wait_idle(cyc);
    chk("drop_hold", 32'(Drop_cnt), 32'd255);
    chk("drop_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-clock while a header is being offered
    Tx_ready = 1'b0;
    DEBUG_RF_dump = pat_inc();
    push_frame(pat_inc(), 8'h6A);
    send_trig();
    #3 RST = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_valid", 32'(Tx_valid), 32'd0);
    chk("arst_data", 32'(Tx_data), 32'd0);
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_drop", 32'(Drop_cnt), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;

    // Back-to-back: Trig on the CHK accept cycle
    Tx_ready = 1'b1;
    DEBUG_RF_dump = pat_inc();
    push_frame(pat_inc(), 8'h6A);
    pb = pat_rand();
    send_trig();
    repeat (29) @(posedge CLK);
    #1;
    chk("b2b_chk_offered", 32'(Tx_data), 32'h6A);
    Trig = 1'b1;
    DEBUG_RF_dump = pb;
    push_auto(pb);
    @(posedge CLK); #1 Trig = 1'b0;
    chk("b2b_valid", 32'(Tx_valid), 32'd1);
    chk("b2b_header", 32'(Tx_data), 32'hA5);
    wait_idle(cyc);
    chk("b2b_cycles", 32'(cyc), 32'd30);
    chk("b2b_drop", 32'(Drop_cnt), 32'd0);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during payload byte 10, then a fresh frame
    p = pat_rand();
    DEBUG_RF_dump = p;
    push_auto(p);
    send_trig();
    repeat (11) @(posedge CLK);
    #1;
    chk("mid_byte10", 32'(Tx_data), 32'(p[(NB-1-10)*8 +: 8]));
    #2 RST = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 32'(Tx_valid), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("mid_no_resume", 32'(Tx_valid), 32'd0);
    DEBUG_RF_dump = pat_inc();
    push_frame(pat_inc(), 8'h6A);
    send_trig();
    wait_idle(cyc);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
